// File: rtl/jtag_host_pkg.sv
// jtag_host_pkg: shared types and constants for the JTAG host shifter
package jtag_host_pkg;
  typedef enum logic [1:0] {IDLE, LOW, HIGH, RESP} state_t;
  localparam int LEN_W = 5;
  localparam int DATA_W = 32;
  localparam logic TMS_RST = 1'b1;
endpackage

// File: rtl/jtag_host_sync2.sv
// jtag_host_sync2: two-flop synchroniser for the asynchronous tdo input
module jtag_host_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift tdo through two flops to settle metastability
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
endmodule

// File: rtl/jtag_host_shifter.sv
// jtag_host_shifter: command/response driven JTAG initiator shifting up to 32 TMS/TDI bits
module jtag_host_shifter import jtag_host_pkg::*; #(
  parameter int DIV = 4,
  parameter bit SYNC_TDO = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_tms,
  input  logic [DATA_W-1:0] cmd_tdi,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_tdo,
  output logic              tck,
  output logic              tms,
  output logic              tdi,
  input  logic              tdo
);
  state_t state, state_n;
  logic [7:0] cnt;
  logic [LEN_W-1:0] idx, idx_n, len;
  logic [DATA_W-1:0] tms_r, tdi_r;
  logic tdo_s, accept, phase_end, last;
  if (SYNC_TDO) begin : g_sync
    jtag_host_sync2 u_sync (.clk(clk), .rst_n(rst_n), .d(tdo), .q(tdo_s));
  end else begin : g_raw
    assign tdo_s = tdo;
  end
  assign accept = state == IDLE && cmd_valid && cmd_ready;
  assign phase_end = cnt == 8'(DIV - 1);
  assign last = idx == len;
  assign idx_n = idx + 1'b1;
  assign rsp_valid = state == RESP;
  // state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // next state: LOW and HIGH phases each last DIV cycles, one pair per bit
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: state_n = accept ? LOW : IDLE;
      LOW:  state_n = phase_end ? HIGH : LOW;
      HIGH: state_n = phase_end ? (last ? RESP : LOW) : HIGH;
      RESP: state_n = rsp_ready ? IDLE : RESP;
      default: state_n = IDLE;
    endcase
  end
  // datapath: phase counter, bit index, pin drivers and tdo capture
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
      len <= '0;
      tms_r <= '0;
      tdi_r <= '0;
      tck <= 1'b0;
      tms <= TMS_RST;
      tdi <= 1'b0;
      rsp_tdo <= '0;
      cmd_ready <= 1'b1;
    end else begin
      tck <= state_n == HIGH;
      cmd_ready <= state == IDLE && !accept;
      cnt <= (state inside {LOW, HIGH} && !phase_end) ? cnt + 8'd1 : 8'd0;
      if (accept) begin
        len <= cmd_len;
        tms_r <= cmd_tms;
        tdi_r <= cmd_tdi;
        idx <= '0;
        tms <= cmd_tms[0];
        tdi <= cmd_tdi[0];
        rsp_tdo <= '0;
      end
      if (state == HIGH && phase_end) begin
        rsp_tdo[idx] <= tdo_s;
        if (!last) begin
          idx <= idx_n;
          tms <= tms_r[idx_n];
          tdi <= tdi_r[idx_n];
        end
      end
    end
endmodule

// File: tb/tb_jtag_host_shifter.sv
// tb_jtag_host_shifter: directed and randomized checks of the JTAG host shifter against a TAP model
module tb_jtag_host_shifter;
  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;
  logic cmd_valid = 1'b0, rsp_ready = 1'b0;
  logic cmd_ready, rsp_valid, tck, tms, tdi, tdo;
  logic [4:0] cmd_len = '0;
  logic [31:0] cmd_tms = '0, cmd_tdi = '0, rsp_tdo;
  logic c1_valid = 1'b0, r1_ready = 1'b0;
  logic c1_ready, r1_valid, tck1, tms1, tdi1;
  logic [4:0] c1_len = '0;
  logic [31:0] c1_tms = '0, c1_tdi = '0, r1_tdo;
  jtag_host_shifter #(.DIV(4), .SYNC_TDO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_tms(cmd_tms), .cmd_tdi(cmd_tdi),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_tdo(rsp_tdo),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo));
  jtag_host_shifter #(.DIV(1), .SYNC_TDO(0)) u1 (
    .clk(clk), .rst_n(rst_n), .cmd_valid(c1_valid), .cmd_ready(c1_ready),
    .cmd_len(c1_len), .cmd_tms(c1_tms), .cmd_tdi(c1_tdi),
    .rsp_valid(r1_valid), .rsp_ready(r1_ready), .rsp_tdo(r1_tdo),
    .tck(tck1), .tms(tms1), .tdi(tdi1), .tdo(tdi1));
  int vectors = 0, errors = 0;
  // tdo source: 0 = TAP model, 1 = random pattern changing on falling tck, 2 = tied high
  int mode = 0;
  logic [31:0] pat = '0;
  int neg_cnt = 0, neg_base = 0, pbase = 0;
  logic tap_tdo = 1'b0;
  wire rnd_tdo = pat[5'(neg_cnt - neg_base)];
  assign tdo = mode == 0 ? tap_tdo : mode == 1 ? rnd_tdo : 1'b1;
  always @(negedge tck) neg_cnt <= neg_cnt + 1;
  bit mon_tms[$], mon_tdi[$];
  always @(posedge tck) begin
    mon_tms.push_back(tms);
    mon_tdi.push_back(tdi);
  end
  typedef enum int {TLR, RTI, SELDR, CAPDR, SHDR, EX1DR, PADR, EX2DR, UPDR,
                    SELIR, CAPIR, SHIR, EX1IR, PAIR, EX2IR, UPIR} tap_t;
  localparam logic [31:0] IDCODE = 32'h1DEAD3FF;
  tap_t tap_st = RTI;
  logic [31:0] dr = '0;
  function automatic tap_t tap_next(tap_t s, logic m);
    case (s)
      TLR:   return m ? TLR : RTI;
      RTI:   return m ? SELDR : RTI;
      SELDR: return m ? SELIR : CAPDR;
      CAPDR: return m ? EX1DR : SHDR;
      SHDR:  return m ? EX1DR : SHDR;
      EX1DR: return m ? UPDR : PADR;
      PADR:  return m ? EX2DR : PADR;
      EX2DR: return m ? UPDR : SHDR;
      UPDR:  return m ? SELDR : RTI;
      SELIR: return m ? TLR : CAPIR;
      CAPIR: return m ? EX1IR : SHIR;
      SHIR:  return m ? EX1IR : SHIR;
      EX1IR: return m ? UPIR : PAIR;
      PAIR:  return m ? EX2IR : PAIR;
      EX2IR: return m ? UPIR : SHIR;
      default: return m ? SELDR : RTI;
    endcase
  endfunction
  always @(posedge tck) begin
    if (tap_st == SHDR) dr <= {tdi, dr[31:1]};
    else if (tap_st == CAPDR) dr <= IDCODE;
    tap_st <= tap_next(tap_st, tms);
  end
  always @(negedge tck) tap_tdo <= tap_st == SHDR ? dr[0] : 1'b0;
  function automatic logic [31:0] mask(int n);
    return 32'((64'd1 << (n + 1)) - 64'd1);
  endfunction
  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run0(input logic [4:0] len, input logic [31:0] t_ms, input logic [31:0] t_di,
                      input logic [31:0] exp_tdo, input bit chk_wave);
    int w, lat, n;
    logic [31:0] ot, od;
    w = 0;
    while (!cmd_ready && w < 100) begin step(); w++; end
    check("cmd_ready_idle", cmd_ready, 1);
    pbase = mon_tms.size();
    neg_base = neg_cnt;
    cmd_valid = 1'b1; cmd_len = len; cmd_tms = t_ms; cmd_tdi = t_di;
    step();
    cmd_valid = 1'b0; cmd_len = 5'($urandom); cmd_tms = $urandom; cmd_tdi = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 400) begin
      if (chk_wave) begin
        check("tck_wave", tck, ((lat - 1) / 4) % 2);
        check("tms_wave", tms, 1);
      end
      step();
      lat++;
    end
    check("latency", lat, (int'(len) + 1) * 8 + 1);
    check("rsp_tdo", rsp_tdo, exp_tdo);
    n = mon_tms.size() - pbase;
    check("pulses", n, int'(len) + 1);
    ot = '0; od = '0;
    for (int i = 0; i < n && i < 32; i++) begin
      ot[i] = mon_tms[pbase + i];
      od[i] = mon_tdi[pbase + i];
    end
    check("tms_seq", ot, t_ms & mask(len));
    check("tdi_seq", od, t_di & mask(len));
    check("tck_resp", tck, 0);
    check("tms_hold", tms, t_ms[len]);
    check("tdi_hold", tdi, t_di[len]);
  endtask
  task automatic take_rsp();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    check("rsp_drop", rsp_valid, 0);
    check("ready_gap", cmd_ready, 0);
    step();
    check("ready_back", cmd_ready, 1);
  endtask
  initial begin
    logic [4:0] l;
    logic [31:0] a, b, e;
    int w;
    bit seen;
    repeat (3) step();
    check("rst_tck", tck, 0);
    check("rst_tms", tms, 1);
    check("rst_tdi", tdi, 0);
    check("rst_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_tdo", rsp_tdo, 0);
    rst_n = 1'b1;
    step();
    mode = 0;
    run0(5'd4, 32'h1F, 32'h0, 32'h0, 1'b1);
    check("tap_reset", tap_st, TLR);
    take_rsp();
    run0(5'd3, 32'h2, 32'h0, 32'h0, 1'b0);
    check("tap_shift", tap_st, SHDR);
    take_rsp();
    run0(5'd31, 32'h80000000, 32'h0, IDCODE, 1'b0);
    check("tap_exit1", tap_st, EX1DR);
    take_rsp();
    mode = 2;
    run0(5'd0, 32'h0, 32'h1, 32'h1, 1'b0);
    take_rsp();
    mode = 1;
    pat = $urandom;
    l = 5'($urandom);
    a = $urandom; b = $urandom;
    e = pat & mask(l);
    run0(l, a, b, e, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("bp_valid", rsp_valid, 1);
      check("bp_tdo", rsp_tdo, e);
      check("bp_ready", cmd_ready, 0);
      check("bp_tck", tck, 0);
    end
    take_rsp();
    for (int k = 0; k < 6; k++) begin
      pat = $urandom;
      l = 5'($urandom);
      a = $urandom; b = $urandom;
      run0(l, a, b, pat & mask(l), 1'b0);
      take_rsp();
    end
    pat = $urandom;
    pbase = mon_tms.size();
    neg_base = neg_cnt;
    cmd_valid = 1'b1; cmd_len = 5'd20; cmd_tms = $urandom; cmd_tdi = $urandom;
    step();
    cmd_valid = 1'b0;
    w = 0;
    while (mon_tms.size() - pbase < 11 && w < 400) begin step(); w++; end
    check("reached_bit10", mon_tms.size() - pbase, 11);
    rst_n = 1'b0;
    #1;
    check("abort_tck", tck, 0);
    check("abort_tms", tms, 1);
    check("abort_tdi", tdi, 0);
    check("abort_valid", rsp_valid, 0);
    check("abort_ready", cmd_ready, 1);
    check("abort_tdo", rsp_tdo, 0);
    repeat (3) step();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      step();
      seen |= rsp_valid;
    end
    check("no_rsp_after_abort", seen, 0);
    pat = $urandom;
    l = 5'($urandom);
    a = $urandom; b = $urandom;
    run0(l, a, b, pat & mask(l), 1'b0);
    take_rsp();
    for (int k = 0; k < 4; k++) begin
      l = k == 0 ? 5'd7 : 5'($urandom);
      b = k == 0 ? 32'hA5 : $urandom;
      w = 0;
      while (!c1_ready && w < 100) begin step(); w++; end
      check("lb_ready", c1_ready, 1);
      c1_valid = 1'b1; c1_len = l; c1_tdi = b; c1_tms = $urandom;
      step();
      c1_valid = 1'b0;
      w = 1;
      while (!r1_valid && w < 200) begin step(); w++; end
      check("lb_latency", w, (int'(l) + 1) * 2 + 1);
      check("lb_tdo", r1_tdo, b & mask(l));
      check("lb_tck", tck1, 0);
      r1_ready = 1'b1;
      step();
      r1_ready = 1'b0;
      check("lb_drop", r1_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
